mem_access_sequencer: RTL

- Host-side initiator for the 8x8 bit memory IC. It is the requesting end of the operation/select control interface that the memory FSM consumes.
- Accepts single or burst read/write commands from a host over a ready/valid handshake.
- Sequences select, operation, address and write data with fixed setup, access and gap timing.
- Captures read data and returns it to the host together with completion strobes.

---
 rtl/mem_access_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mem_access_sequencer.sv
// -----------------------------------------------------------------------------
// mem_access_sequencer
//
// Host-side initiator for the 8x8 bit memory IC. A host hands over single or
// burst read/write commands; the sequencer walks each word through
// SETUP -> ACCESS (ACCESS_CYCLES cycles) -> GAP. During that walk it drives
// select, operation, address and write data toward the memory. It captures
// read data and reports completion back to the host.
//
// Host handshake (valid/ready): a command is transferred on the rising edge
// where i_req && o_ready. o_ready is high only in IDLE. i_req seen in any
// other state is ignored and is not queued.
// Write data follows the same edge rule. i_wdata is taken at acceptance for
// the first word. After that it is taken on each edge where o_wnext is high.
//
// Ports
//   i_clock      system clock (rising edge)
//   i_reset_n    asynchronous active-low reset
//   i_req        host command valid
//   i_we         1 = write, 0 = read
//   i_addr       start word address
//   i_len        burst length minus one (0 = single word)
//   i_wdata      write data (first word, then one word per o_wnext)
//   o_ready      sequencer idle, command can be accepted
//   o_wnext      pulse: next write word is sampled on this edge
//   o_rvalid     pulse: o_rdata holds a fresh read word
//   o_rdata      captured read word (held between reads)
//   o_done       pulse on the final GAP cycle of a command
//   o_operation  to memory: 1 = write, 0 = read
//   o_select     to memory: chip select
//   o_addr       to memory: word address
//   o_wdata      to memory: write data
//   i_rdata      from memory: read data
//   dbg_state    current FSM state (0 IDLE, 1 SETUP, 2 ACCESS, 3 GAP)
// -----------------------------------------------------------------------------
module mem_access_sequencer #(
   parameter int ADDR_W        = 3,
   parameter int DATA_W        = 8,
   parameter int ACCESS_CYCLES = 2
) (
   input  logic              i_clock,
   input  logic              i_reset_n,
   input  logic              i_req,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [ADDR_W-1:0] i_len,
   input  logic [DATA_W-1:0] i_wdata,
   output logic              o_ready,
   output logic              o_wnext,
   output logic              o_rvalid,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_done,
   output logic              o_operation,
   output logic              o_select,
   output logic [ADDR_W-1:0] o_addr,
   output logic [DATA_W-1:0] o_wdata,
   input  logic [DATA_W-1:0] i_rdata,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_GAP    = 2'd3
   } state_t;

   // ACCESS_CYCLES is limited to 1..15, so a 4-bit counter is always enough.
   localparam logic [3:0] ACC_LAST = 4'(ACCESS_CYCLES - 1);

   state_t            state_q, state_d;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] len_q;
   logic [ADDR_W-1:0] word_cnt_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic [3:0]        acc_cnt_q;
   logic              acc_last;
   logic              last_word;

   assign acc_last  = (acc_cnt_q == ACC_LAST);
   assign last_word = (word_cnt_q == len_q);

   // State register. Reset is asynchronous. Select and operation are decoded
   // from this register, so both drop the moment reset asserts.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and control outputs.
   always_comb begin
      state_d     = state_q;
      o_ready     = 1'b0;
      o_select    = 1'b0;
      o_operation = 1'b0;
      o_wnext     = 1'b0;
      o_rvalid    = 1'b0;
      o_done      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            o_ready = 1'b1;
            if (i_req) begin
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            o_select    = 1'b1;
            o_operation = we_q;
            state_d     = ST_ACCESS;
         end
         ST_ACCESS: begin
            o_select    = 1'b1;
            o_operation = we_q;
            if (acc_last) begin
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            o_rvalid = ~we_q;
            o_wnext  = we_q & ~last_word;
            o_done   = last_word;
            state_d  = last_word ? ST_IDLE : ST_SETUP;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Command and datapath registers.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         we_q       <= 1'b0;
         addr_q     <= '0;
         len_q      <= '0;
         word_cnt_q <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         acc_cnt_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_req) begin
                  we_q       <= i_we;
                  addr_q     <= i_addr;
                  len_q      <= i_len;
                  wdata_q    <= i_wdata;
                  word_cnt_q <= '0;
                  acc_cnt_q  <= '0;
               end
            end
            ST_ACCESS: begin
               if (acc_last) begin
                  acc_cnt_q <= '0;
                  // Memory data is valid by the end of the access window.
                  if (!we_q) begin
                     rdata_q <= i_rdata;
                  end
               end else begin
                  acc_cnt_q <= acc_cnt_q + 1'b1;
               end
            end
            ST_GAP: begin
               if (!last_word) begin
                  // The address wraps naturally at 2^ADDR_W.
                  addr_q     <= addr_q + 1'b1;
                  word_cnt_q <= word_cnt_q + 1'b1;
                  if (we_q) begin
                     wdata_q <= i_wdata;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign o_addr    = addr_q;
   assign o_wdata   = wdata_q;
   assign o_rdata   = rdata_q;
   assign dbg_state = state_q;

endmodule
